// File: rtl/tpu_rf_pkg.sv
// Shared definitions for the multi-slot TPU register file: CTRL bit positions,
// register-map offsets and the deferred-write buffer state type.
package tpu_rf_pkg;

    localparam int CTRL_RSTTPU  = 0;
    localparam int CTRL_TXEN    = 1;
    localparam int CTRL_RXEN    = 2;
    localparam int CTRL_MSK     = 3;
    localparam int CTRL_INTFLAG = 4;
    localparam int CTRL_WRPEND  = 5;
    localparam int CTRL_DROP    = 6;

    localparam int CTRL_OFS = 0;
    localparam int SLOT_OFS = 1;

    // Timer bytes sit directly after the last RX slot.
    function automatic int timer_ofs(input int n_slots);
        return 1 + 2 * n_slots;
    endfunction

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} wbuf_state_t;

endpackage

// File: rtl/tpu_rf_wbuf.sv
// One-entry deferred-write buffer: holds a bus write that arrives during a slot
// match and replays it once the match clears; later writes while full are dropped.
module tpu_rf_wbuf
    import tpu_rf_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              SYS_CLK,
    input  logic              RST_N,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              hit,
    output logic              commit,
    output logic [ADDR_W-1:0] commit_addr,
    output logic [DATA_W-1:0] commit_data,
    output logic              wr_pend,
    output logic              drop
);

    wbuf_state_t       state, next_state;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            buf_addr <= '0;
            buf_data <= '0;
        end else if (state == IDLE && we && hit) begin
            buf_addr <= addr;
            buf_data <= data;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (we && hit) next_state = HOLD;
            HOLD:    if (!hit)      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The buffered write takes priority on the replay edge; a concurrent bus write is lost.
    always_comb begin
        commit      = 1'b0;
        commit_addr = addr;
        commit_data = data;
        wr_pend     = 1'b0;
        drop        = 1'b0;
        case (state)
            IDLE: commit = we && !hit;
            HOLD: begin
                commit      = !hit;
                commit_addr = buf_addr;
                commit_data = buf_data;
                wr_pend     = 1'b1;
                drop        = we;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tpu_rf_mc.sv
// Multi-slot TPU register file: N_SLOTS TX/RX slot pairs, CTRL and timer value,
// with slot-hit write deferral, sticky edge-detected interrupt and TPU reset pulse.
module tpu_rf_mc
    import tpu_rf_pkg::*;
#(
    parameter int              ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h20,
    parameter int              DATA_W    = 8,
    parameter int              N_SLOTS   = 4,
    parameter int              TIMER_W   = 16
) (
    input  logic                        SYS_CLK,
    input  logic                        RST_N,
    input  logic                        we_rf,
    input  logic [ADDR_W-1:0]           addr_rf,
    input  logic [DATA_W-1:0]           data_rf,
    input  logic [DATA_W-1:0]           TIME,
    input  logic                        TPUINT_RF,
    output logic                        ready_rf,
    output logic                        RSTTPU,
    output logic                        TXSLOT_EN,
    output logic                        RXSLOT_EN,
    output logic                        TIMERINTMSK,
    output logic                        INTFLAG,
    output logic                        IRQ,
    output logic [N_SLOTS*DATA_W-1:0]   TX_SLOT,
    output logic [N_SLOTS*DATA_W-1:0]   RX_SLOT,
    output logic [TIMER_W-1:0]          TIMER_INT_VALUE,
    output logic [DATA_W-1:0]           data_out
);

    localparam int TIMER_OFS   = timer_ofs(N_SLOTS);
    localparam int TIMER_BYTES = TIMER_W / DATA_W;

    logic [DATA_W-1:0] tx_q [N_SLOTS];
    logic [DATA_W-1:0] rx_q [N_SLOTS];
    logic [TIMER_W-1:0] timer_q;
    logic rsttpu_q, txen_q, rxen_q, msk_q, intflag_q, drop_q, tpuint_q;

    logic              hit, commit, wr_pend, drop_set, ctrl_wr, rise;
    logic [ADDR_W-1:0] commit_addr, wofs, rofs;
    logic [DATA_W-1:0] commit_data, ctrl_rd;

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if ((txen_q && TIME == tx_q[k]) || (rxen_q && TIME == rx_q[k])) hit = 1'b1;
        end
    end

    tpu_rf_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
        .SYS_CLK     (SYS_CLK),
        .RST_N       (RST_N),
        .we          (we_rf),
        .addr        (addr_rf),
        .data        (data_rf),
        .hit         (hit),
        .commit      (commit),
        .commit_addr (commit_addr),
        .commit_data (commit_data),
        .wr_pend     (wr_pend),
        .drop        (drop_set)
    );

    assign wofs    = commit_addr - BASE_ADDR;
    assign rofs    = addr_rf - BASE_ADDR;
    assign ctrl_wr = commit && (wofs == ADDR_W'(CTRL_OFS));
    assign rise    = TPUINT_RF && !tpuint_q;

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                tx_q[k] <= '0;
                rx_q[k] <= '0;
            end
            timer_q <= '0;
        end else if (commit) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                if (wofs == ADDR_W'(SLOT_OFS + 2*k))     tx_q[k] <= commit_data;
                if (wofs == ADDR_W'(SLOT_OFS + 1 + 2*k)) rx_q[k] <= commit_data;
            end
            for (int j = 0; j < TIMER_BYTES; j++) begin
                if (wofs == ADDR_W'(TIMER_OFS + j))
                    timer_q[(TIMER_BYTES-1-j)*DATA_W +: DATA_W] <= commit_data;
            end
        end
    end

    // Set events (interrupt edge, dropped write) override a same-edge write-1-to-clear.
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsttpu_q  <= 1'b0;
            txen_q    <= 1'b0;
            rxen_q    <= 1'b0;
            msk_q     <= 1'b0;
            intflag_q <= 1'b0;
            drop_q    <= 1'b0;
            tpuint_q  <= 1'b0;
        end else begin
            rsttpu_q <= ctrl_wr && commit_data[CTRL_RSTTPU];
            tpuint_q <= TPUINT_RF;
            if (ctrl_wr) begin
                txen_q <= commit_data[CTRL_TXEN];
                rxen_q <= commit_data[CTRL_RXEN];
                msk_q  <= commit_data[CTRL_MSK];
            end
            if (rise)                                       intflag_q <= 1'b1;
            else if (ctrl_wr && commit_data[CTRL_INTFLAG]) intflag_q <= 1'b0;
            if (drop_set)                                   drop_q <= 1'b1;
            else if (ctrl_wr && commit_data[CTRL_DROP])    drop_q <= 1'b0;
        end
    end

    always_comb begin
        ctrl_rd               = '0;
        ctrl_rd[CTRL_RSTTPU]  = rsttpu_q;
        ctrl_rd[CTRL_TXEN]    = txen_q;
        ctrl_rd[CTRL_RXEN]    = rxen_q;
        ctrl_rd[CTRL_MSK]     = msk_q;
        ctrl_rd[CTRL_INTFLAG] = intflag_q;
        ctrl_rd[CTRL_WRPEND]  = wr_pend;
        ctrl_rd[CTRL_DROP]    = drop_q;
    end

    always_comb begin
        data_out = '0;
        if (rofs == ADDR_W'(CTRL_OFS)) data_out = ctrl_rd;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (rofs == ADDR_W'(SLOT_OFS + 2*k))     data_out = tx_q[k];
            if (rofs == ADDR_W'(SLOT_OFS + 1 + 2*k)) data_out = rx_q[k];
        end
        for (int j = 0; j < TIMER_BYTES; j++) begin
            if (rofs == ADDR_W'(TIMER_OFS + j))
                data_out = timer_q[(TIMER_BYTES-1-j)*DATA_W +: DATA_W];
        end
    end

    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot_out
        assign TX_SLOT[k*DATA_W +: DATA_W] = tx_q[k];
        assign RX_SLOT[k*DATA_W +: DATA_W] = rx_q[k];
    end

    assign ready_rf        = !hit && !wr_pend;
    assign RSTTPU          = rsttpu_q;
    assign TXSLOT_EN       = txen_q;
    assign RXSLOT_EN       = rxen_q;
    assign TIMERINTMSK     = msk_q;
    assign INTFLAG         = intflag_q;
    assign IRQ             = intflag_q && msk_q;
    assign TIMER_INT_VALUE = timer_q;

endmodule

// File: tb/tb_tpu_rf_mc.sv
// Self-checking bench for tpu_rf_mc: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a register-map level model.
module tb_tpu_rf_mc;

    localparam int N_SLOTS = 4;
    localparam logic [7:0] BASE = 8'h20;

    logic        SYS_CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        we_rf = 1'b0;
    logic [7:0]  addr_rf = 8'h00;
    logic [7:0]  data_rf = 8'h00;
    logic [7:0]  TIME = 8'h00;
    logic        TPUINT_RF = 1'b0;
    logic        ready_rf, RSTTPU, TXSLOT_EN, RXSLOT_EN, TIMERINTMSK, INTFLAG, IRQ;
    logic [31:0] TX_SLOT, RX_SLOT;
    logic [15:0] TIMER_INT_VALUE;
    logic [7:0]  data_out;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    tpu_rf_mc #(.ADDR_W(8), .BASE_ADDR(8'h20), .DATA_W(8), .N_SLOTS(N_SLOTS), .TIMER_W(16)) dut (
        .SYS_CLK(SYS_CLK), .RST_N(RST_N), .we_rf(we_rf), .addr_rf(addr_rf), .data_rf(data_rf),
        .TIME(TIME), .TPUINT_RF(TPUINT_RF), .ready_rf(ready_rf), .RSTTPU(RSTTPU),
        .TXSLOT_EN(TXSLOT_EN), .RXSLOT_EN(RXSLOT_EN), .TIMERINTMSK(TIMERINTMSK),
        .INTFLAG(INTFLAG), .IRQ(IRQ), .TX_SLOT(TX_SLOT), .RX_SLOT(RX_SLOT),
        .TIMER_INT_VALUE(TIMER_INT_VALUE), .data_out(data_out)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    // Reference model: register contents plus a queue of pending (addr,data) writes.
    logic [7:0]  m_tx [N_SLOTS];
    logic [7:0]  m_rx [N_SLOTS];
    logic [15:0] m_timer;
    bit          m_rst, m_txen, m_rxen, m_msk, m_flag, m_drop, m_prev;
    logic [15:0] m_pend [$];

    function automatic void m_reset();
        for (int k = 0; k < N_SLOTS; k++) begin
            m_tx[k] = 8'h00;
            m_rx[k] = 8'h00;
        end
        m_timer = 16'h0000;
        {m_rst, m_txen, m_rxen, m_msk, m_flag, m_drop, m_prev} = '0;
        m_pend.delete();
    endfunction

    function automatic bit m_hit();
        for (int k = 0; k < N_SLOTS; k++) begin
            if (m_txen && TIME == m_tx[k]) return 1'b1;
            if (m_rxen && TIME == m_rx[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int ofs = int'(a) - int'(BASE);
        if (ofs == 0)
            return {1'b0, m_drop, m_pend.size() != 0, m_flag, m_msk, m_rxen, m_txen, m_rst};
        if (ofs >= 1 && ofs <= 2*N_SLOTS)
            return ((ofs - 1) % 2 == 0) ? m_tx[(ofs-1)/2] : m_rx[(ofs-1)/2];
        if (ofs == 2*N_SLOTS + 1) return m_timer[15:8];
        if (ofs == 2*N_SLOTS + 2) return m_timer[7:0];
        return 8'h00;
    endfunction

    function automatic void m_write(input logic [7:0] a, input logic [7:0] d);
        int ofs = int'(a) - int'(BASE);
        if (ofs == 0) begin
            m_rst  = d[0];
            m_txen = d[1];
            m_rxen = d[2];
            m_msk  = d[3];
            if (d[4]) m_flag = 1'b0;
            if (d[6]) m_drop = 1'b0;
        end else if (ofs >= 1 && ofs <= 2*N_SLOTS) begin
            if ((ofs - 1) % 2 == 0) m_tx[(ofs-1)/2] = d;
            else                    m_rx[(ofs-1)/2] = d;
        end else if (ofs == 2*N_SLOTS + 1) begin
            m_timer[15:8] = d;
        end else if (ofs == 2*N_SLOTS + 2) begin
            m_timer[7:0] = d;
        end
    endfunction

    always @(posedge SYS_CLK or negedge RST_N) begin
        bit          hit_now, rise, drop_now, do_commit;
        logic [15:0] wr;
        if (!RST_N) begin
            m_reset();
        end else begin
            hit_now   = m_hit();
            rise      = TPUINT_RF && !m_prev;
            drop_now  = 1'b0;
            do_commit = 1'b0;
            wr        = {addr_rf, data_rf};
            if (m_pend.size() == 0) begin
                if (we_rf && !hit_now) do_commit = 1'b1;
                else if (we_rf)        m_pend.push_back({addr_rf, data_rf});
            end else begin
                drop_now = we_rf;
                if (!hit_now) begin
                    do_commit = 1'b1;
                    wr = m_pend.pop_front();
                end
            end
            m_rst = 1'b0;
            if (do_commit) m_write(wr[15:8], wr[7:0]);
            if (rise)      m_flag = 1'b1;
            if (drop_now)  m_drop = 1'b1;
            m_prev = TPUINT_RF;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        logic [31:0] etx, erx;
        for (int k = 0; k < N_SLOTS; k++) begin
            etx[k*8 +: 8] = m_tx[k];
            erx[k*8 +: 8] = m_rx[k];
        end
        checkOutput("ready_rf", 32'(ready_rf), 32'(!m_hit() && m_pend.size() == 0));
        checkOutput("RSTTPU", 32'(RSTTPU), 32'(m_rst));
        checkOutput("TXSLOT_EN", 32'(TXSLOT_EN), 32'(m_txen));
        checkOutput("RXSLOT_EN", 32'(RXSLOT_EN), 32'(m_rxen));
        checkOutput("TIMERINTMSK", 32'(TIMERINTMSK), 32'(m_msk));
        checkOutput("INTFLAG", 32'(INTFLAG), 32'(m_flag));
        checkOutput("IRQ", 32'(IRQ), 32'(m_flag && m_msk));
        checkOutput("TX_SLOT", TX_SLOT, etx);
        checkOutput("RX_SLOT", RX_SLOT, erx);
        checkOutput("TIMER_INT_VALUE", 32'(TIMER_INT_VALUE), 32'(m_timer));
        checkOutput("data_out", 32'(data_out), 32'(m_read(addr_rf)));
    endtask

    always @(negedge SYS_CLK) begin
        if (cmp_en) checkModel();
    end

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic applyStimulus(input bit we, input logic [7:0] a, input logic [7:0] d);
        tick();
        we_rf   = we;
        addr_rf = a;
        data_rf = d;
    endtask

    // Drives one write strobe; returns just after the edge that samples it.
    task automatic wrReg(input logic [7:0] a, input logic [7:0] d);
        applyStimulus(1'b1, a, d);
        applyStimulus(1'b0, a, d);
    endtask

    initial begin
        m_reset();
        #1 RST_N = 1'b0;
        #1;
        checkOutput("rst_TX_SLOT", TX_SLOT, 32'h0);
        checkOutput("rst_TIMER", 32'(TIMER_INT_VALUE), 32'h0);
        checkOutput("rst_INTFLAG", 32'(INTFLAG), 32'h0);
        checkOutput("rst_RSTTPU", 32'(RSTTPU), 32'h0);
        checkOutput("rst_ready", 32'(ready_rf), 32'h1);
        cmp_en = 1'b1;
        @(negedge SYS_CLK);
        @(negedge SYS_CLK);
        RST_N = 1'b1;

        // Slot and control setup with no hit possible.
        TIME = 8'h00;
        wrReg(8'h21, 8'h05);
        wrReg(8'h22, 8'h09);
        wrReg(8'h20, 8'h06);
        checkOutput("t1_tx0", 32'(TX_SLOT[7:0]), 32'h05);
        checkOutput("t1_rx0", 32'(RX_SLOT[7:0]), 32'h09);
        checkOutput("t1_en", 32'({TXSLOT_EN, RXSLOT_EN}), 32'h3);
        checkOutput("t1_ctrl", 32'(data_out), 32'h06);
        TIME = 8'h80;
        #1 checkOutput("t1_ready", 32'(ready_rf), 32'h1);

        // Write during a hit is held, a second write is dropped, then replay.
        TIME = 8'h05;
        wrReg(8'h27, 8'h33);
        checkOutput("t2_ready", 32'(ready_rf), 32'h0);
        checkOutput("t2_hidden", 32'(data_out), 32'h00);
        checkOutput("t2_tx3", 32'(TX_SLOT[31:24]), 32'h00);
        addr_rf = 8'h20;
        #1 checkOutput("t2_wrpend", 32'(data_out), 32'h26);
        wrReg(8'h29, 8'hAB);
        checkOutput("t3_timer", 32'(TIMER_INT_VALUE), 32'h0);
        addr_rf = 8'h20;
        #1 checkOutput("t3_drop", 32'(data_out), 32'h66);
        TIME = 8'h06;
        tick();
        checkOutput("t2_tx3_commit", 32'(TX_SLOT[31:24]), 32'h33);
        checkOutput("t2_ready_back", 32'(ready_rf), 32'h1);
        checkOutput("t3_timer_after", 32'(TIMER_INT_VALUE), 32'h0);
        wrReg(8'h20, 8'h46);
        checkOutput("t3_drop_clr", 32'(data_out), 32'h06);

        // RSTTPU pulse.
        wrReg(8'h20, 8'h0F);
        checkOutput("t4_pulse", 32'(RSTTPU), 32'h1);
        tick();
        checkOutput("t4_pulse_end", 32'(RSTTPU), 32'h0);
        checkOutput("t4_ctrl", 32'(data_out), 32'h0E);

        // Interrupt flag: set on edge, W1C, set beats clear.
        TPUINT_RF = 1'b1;
        tick();
        checkOutput("t5_flag", 32'(INTFLAG), 32'h1);
        checkOutput("t5_irq", 32'(IRQ), 32'h1);
        repeat (4) tick();
        wrReg(8'h20, 8'h18);
        checkOutput("t5_w1c", 32'(INTFLAG), 32'h0);
        TPUINT_RF = 1'b0;
        tick();
        applyStimulus(1'b1, 8'h20, 8'h18);
        TPUINT_RF = 1'b1;
        applyStimulus(1'b0, 8'h20, 8'h18);
        checkOutput("t5_set_wins", 32'(INTFLAG), 32'h1);
        TPUINT_RF = 1'b0;

        // Reset while a write is held discards it.
        wrReg(8'h20, 8'h06);
        TIME = 8'h05;
        wrReg(8'h2A, 8'h77);
        checkOutput("t6_held", 32'(ready_rf), 32'h0);
        #3 RST_N = 1'b0;
        #1;
        checkOutput("t6_rst_tx", TX_SLOT, 32'h0);
        checkOutput("t6_rst_en", 32'({TXSLOT_EN, RXSLOT_EN, TIMERINTMSK}), 32'h0);
        checkOutput("t6_rst_flag", 32'({INTFLAG, IRQ, RSTTPU}), 32'h0);
        @(negedge SYS_CLK);
        RST_N = 1'b1;
        TIME = 8'h06;
        repeat (3) tick();
        addr_rf = 8'h2A;
        #1;
        checkOutput("t6_no_commit", 32'(data_out), 32'h00);
        checkOutput("t6_timer", 32'(TIMER_INT_VALUE), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] a, d;
            a = 8'(($urandom_range(0, 14)) + 8'h1E);
            d = (a >= 8'h21 && a <= 8'h28) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            applyStimulus($urandom_range(0, 2) == 0, a, d);
            TIME = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) TPUINT_RF = ~TPUINT_RF;
            if ($urandom_range(0, 299) == 0) begin
                RST_N = 1'b0;
                #2 RST_N = 1'b1;
            end
        end
        tick();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tpu_rf_mc.md
Name: tpu_rf_mc

Overview:
Parametrised multi-slot TPU register file, successor to the single TX/RX-slot register file. It sits between the host register bus and the TPU core. It holds N_SLOTS TX/RX slot pairs, a control register and the timer interrupt value. It adds a one-entry deferred-write buffer for writes that arrive during a slot match, a sticky edge-detected interrupt flag with write-1-to-clear, and a self-clearing TPU reset pulse.

Parameters:
BASE_ADDR, 8'h20, address of CTRL; all other registers follow contiguously.
ADDR_W, 8, register bus address width.
DATA_W, 8, register and bus data width.
N_SLOTS, 4, number of TX/RX slot pairs (1..8).
TIMER_W, 16, timer interrupt value width; must be a multiple of DATA_W.

Ports:
SYS_CLK  in  1  system clock.
RST_N  in  1  asynchronous, active-low reset.
we_rf  in  1  write strobe.
addr_rf  in  ADDR_W  register address.
data_rf  in  DATA_W  write data.
TIME  in  DATA_W  current TPU slot time.
TPUINT_RF  in  1  timer interrupt event from the TPU, level.
ready_rf  out  1  register file accepts a write this cycle.
RSTTPU  out  1  one-cycle TPU reset pulse.
TXSLOT_EN  out  1  global TX slot enable.
RXSLOT_EN  out  1  global RX slot enable.
TIMERINTMSK  out  1  interrupt enable (1 = enabled).
INTFLAG  out  1  sticky interrupt flag.
IRQ  out  1  INTFLAG & TIMERINTMSK.
TX_SLOT  out  N_SLOTS*DATA_W  TX slot k at [k*DATA_W +: DATA_W].
RX_SLOT  out  N_SLOTS*DATA_W  RX slot k at [k*DATA_W +: DATA_W].
TIMER_INT_VALUE  out  TIMER_W  timer compare value.
data_out  out  DATA_W  combinational read of addr_rf.

Behaviour:
- Register map:
  - CTRL at BASE.
  - TX_SLOT[k] at BASE+1+2k; RX_SLOT[k] at BASE+2+2k.
  - Timer bytes follow, most significant byte first (defaults: 0x29 = [15:8], 0x2A = [7:0]).
  - Unmapped reads return 0; unmapped writes are ignored but still pass through the buffer rules.
- CTRL bits:
  - [0] RSTTPU: write 1 produces a one-cycle pulse; hardware clears it the next cycle.
  - [1] TXSLOT_EN, [2] RXSLOT_EN, [3] TIMERINTMSK: read/write.
  - [4] INTFLAG: write 1 clears; write 0 has no effect.
  - [5] WR_PEND: read-only.
  - [6] DROP: sticky; write 1 clears.
  - [7] reserved, reads 0.
- Reset (RST_N low, async): all registers 0, buffer IDLE, edge detector 0, so all outputs are 0. Release of RST_N is synchronised externally. ready_rf = 1 after reset (all slots 0 while TIME == 0 counts as a hit only if the matching enable is set).
- Slot hit: hit = OR over k of (TXSLOT_EN && TIME == TX_SLOT[k]) || (RXSLOT_EN && TIME == RX_SLOT[k]).
- ready_rf = ~hit & (state == IDLE). It is combinational.
- Deferred-write FSM, states IDLE and HOLD:
  - IDLE, we_rf && ~hit: commit in the same clock edge (zero latency).
  - IDLE, we_rf && hit: capture addr/data, go to HOLD, WR_PEND = 1.
  - HOLD, ~hit: commit the buffered write on that edge, return to IDLE.
  - HOLD, we_rf asserted: the new write is dropped and DROP is set. This applies on the commit edge too; the buffered write always wins.
  - Reset in HOLD discards the buffered write.
- INTFLAG:
  - Set on a rising edge of TPUINT_RF; the previous-value register is cleared by reset.
  - A set and a W1C on the same edge: set wins.
  - An edge during HOLD still sets INTFLAG.
- A CTRL write loads bits [3:1] from data. Bits [0], [4] and [6] follow the pulse and W1C rules above.
- A deferred CTRL commit with bit0 = 1 pulses RSTTPU on the commit edge + 1 cycle.
- data_out reflects register contents, including WR_PEND; uncommitted buffered data is not visible.

Decomposition:
- Package tpu_rf_pkg:
  - CTRL bit-index localparams.
  - Offset constants CTRL_OFS = 0, SLOT_OFS = 1, TIMER_OFS = 1+2*N_SLOTS as functions of N_SLOTS.
  - typedef enum logic {IDLE, HOLD} wbuf_state_t.
- Sub-module tpu_rf_wbuf: the deferred-write FSM plus the addr/data holding register. It outputs a commit strobe with commit addr/data, WR_PEND and a drop strobe.
- The top level holds the register array, hit logic, read mux and interrupt logic.

Test Plan:
1. Reset, then write 0x21 = 0x05, 0x22 = 0x09, 0x20 = 0x06 with TIME = 0 -> TX_SLOT[7:0] = 0x05, RX_SLOT[7:0] = 0x09, TXSLOT_EN = RXSLOT_EN = 1, ready_rf = 1, data_out(0x20) = 0x06.
2. With TIME = 0x05, write 0x27 = 0x33 -> ready_rf = 0, WR_PEND = 1, TX_SLOT[31:24] unchanged. Set TIME = 0x06 -> next edge TX_SLOT[31:24] = 0x33, ready_rf = 1.
3. In HOLD, issue a second write 0x29 = 0xAB -> TIMER_INT_VALUE unchanged, DROP = 1 (CTRL[6]). Write 0x20 = 0x46 -> DROP = 0.
4. Write 0x20 = 0x0F with no hit -> RSTTPU high for exactly 1 cycle, then CTRL reads 0x0E.
5. Raise TPUINT_RF and hold it 5 cycles -> INTFLAG = 1 and IRQ = 1 from the next edge. Write 0x20 = 0x18 -> INTFLAG clears. Write 0x20 = 0x18 on the same edge as a new rising edge -> INTFLAG stays 1.
6. Assert RST_N = 0 asynchronously mid-HOLD -> all outputs 0 immediately. After release the buffered write never commits; data_out(0x2A) = 0x00.
